// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared types and timing constants for the DVI frame sampler
package dvi_pkg;

    // One decoded pixel; packs to {r,g,b}.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        S_WAIT_VS = 1'b0,
        S_CAPTURE = 1'b1
    } fsm_t;

    // Nominal 800x600 active area of the source.
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;

endpackage

// File: rtl/dvi_sync_edge.sv
// rtl/dvi_sync_edge.sv - input register stage, vs/de edge detect and x/y pixel counters
//
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   de, vs, rgb     raw receiver stream
//   de_q, rgb_q     stream delayed by one clock
//   vs_rise         first cycle of vs in the registered stream
//   de_fall         first blank cycle after a line in the registered stream
//   x_cnt           position of the current de_q pixel within its line
//   y_cnt           line index of the current de_q pixel within the frame
module dvi_sync_edge
    import dvi_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             de,
    input  logic             vs,
    input  rgb_t             rgb,
    output logic             de_q,
    output rgb_t             rgb_q,
    output logic             vs_rise,
    output logic             de_fall,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic vs_q;
    logic vs_q2;
    logic de_q2;

    assign vs_rise = vs_q & ~vs_q2;
    assign de_fall = ~de_q & de_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            de_q2 <= 1'b0;
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            rgb_q <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            de_q  <= de;
            de_q2 <= de_q;
            vs_q  <= vs;
            vs_q2 <= vs_q;
            rgb_q <= rgb;

            // Counters stick at all-ones so oversized lines/frames never alias
            // back onto low grid positions.
            if (de_fall) begin
                x_cnt <= '0;
            end else if (de_q && (x_cnt != CNT_MAX)) begin
                x_cnt <= x_cnt + 1'b1;
            end

            if (vs_rise) begin
                y_cnt <= '0;
            end else if (de_fall && (y_cnt != CNT_MAX)) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dvi_frame_sampler.sv
// rtl/dvi_frame_sampler.sv - point-samples a MATRIX_W x MATRIX_H grid per frame and measures active size
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   I_enable            capture enable
//   I_de, I_hs, I_vs    receiver timing (hs reserved)
//   I_r, I_g, I_b       receiver pixel
//   O_wr_en/addr/data   frame-store write, addr = row*MATRIX_W+col, data = {r,g,b}
//   O_frame_done        one-cycle pulse when a captured frame ends
//   O_frame_complete    last frame wrote every grid sample
//   O_h_active          longest line of last frame
//   O_v_active          line count of last frame
module dvi_frame_sampler
    import dvi_pkg::*;
#(
    parameter int MATRIX_W = 16,
    parameter int MATRIX_H = 8,
    parameter int X_FIRST  = 25,
    parameter int Y_FIRST  = 37,
    parameter int X_STEP   = 50,
    parameter int Y_STEP   = 75,
    parameter int CNT_W    = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 I_enable,
    input  logic                                 I_de,
    input  logic                                 I_hs,
    input  logic                                 I_vs,
    input  logic [7:0]                           I_r,
    input  logic [7:0]                           I_g,
    input  logic [7:0]                           I_b,
    output logic                                 O_wr_en,
    output logic [$clog2(MATRIX_W*MATRIX_H)-1:0] O_wr_addr,
    output logic [23:0]                          O_wr_data,
    output logic                                 O_frame_done,
    output logic                                 O_frame_complete,
    output logic [CNT_W-1:0]                     O_h_active,
    output logic [CNT_W-1:0]                     O_v_active
);

    localparam int N_SAMPLES = MATRIX_W * MATRIX_H;
    localparam int ADDR_W    = $clog2(N_SAMPLES);
    localparam int COL_W     = $clog2(MATRIX_W + 1);
    localparam int ROW_W     = $clog2(MATRIX_H + 1);
    localparam int SCNT_W    = $clog2(N_SAMPLES + 1);
    // One extra bit so next_x/next_y past the counter range cannot wrap onto a real position.
    localparam int POS_W     = CNT_W + 1;

    localparam logic [POS_W-1:0] X_FIRST_P = POS_W'(X_FIRST);
    localparam logic [POS_W-1:0] Y_FIRST_P = POS_W'(Y_FIRST);
    localparam logic [POS_W-1:0] X_STEP_P  = POS_W'(X_STEP);
    localparam logic [POS_W-1:0] Y_STEP_P  = POS_W'(Y_STEP);

    logic             de_q;
    rgb_t             rgb_q;
    logic             vs_rise;
    logic             de_fall;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;

    fsm_t              state;
    fsm_t              state_nx;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [POS_W-1:0]  next_x;
    logic [POS_W-1:0]  next_y;
    logic [SCNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0]  line_max;

    logic              hit;
    logic              row_adv;
    logic              frame_end;
    logic              x_on;
    logic              y_on;
    logic              col_ok;
    logic              row_ok;
    logic [ADDR_W-1:0] addr_c;

    logic unused_hs;
    assign unused_hs = I_hs;

    dvi_sync_edge #(
        .CNT_W (CNT_W)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .de      (I_de),
        .vs      (I_vs),
        .rgb     ('{r: I_r, g: I_g, b: I_b}),
        .de_q    (de_q),
        .rgb_q   (rgb_q),
        .vs_rise (vs_rise),
        .de_fall (de_fall),
        .x_cnt   (x_cnt),
        .y_cnt   (y_cnt)
    );

    assign x_on   = ({1'b0, x_cnt} == next_x);
    assign y_on   = ({1'b0, y_cnt} == next_y);
    assign col_ok = (col < COL_W'(MATRIX_W));
    assign row_ok = (row < ROW_W'(MATRIX_H));
    assign addr_c = ADDR_W'(int'(row) * MATRIX_W + int'(col));

    always_comb begin
        state_nx  = state;
        hit       = 1'b0;
        row_adv   = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_WAIT_VS: begin
                if (vs_rise && I_enable) begin
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // vs_rise wins over everything, including a coincident de pixel.
                if (vs_rise) begin
                    frame_end = 1'b1;
                    if (!I_enable) begin
                        state_nx = S_WAIT_VS;
                    end
                end else if (!I_enable) begin
                    state_nx = S_WAIT_VS;
                end else begin
                    hit     = de_q & x_on & y_on & col_ok & row_ok;
                    row_adv = de_fall & y_on & row_ok;
                end
            end
            default: state_nx = S_WAIT_VS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_WAIT_VS;
            col              <= '0;
            row              <= '0;
            next_x           <= '0;
            next_y           <= '0;
            sample_cnt       <= '0;
            line_max         <= '0;
            O_wr_en          <= 1'b0;
            O_wr_addr        <= '0;
            O_wr_data        <= '0;
            O_frame_done     <= 1'b0;
            O_frame_complete <= 1'b0;
            O_h_active       <= '0;
            O_v_active       <= '0;
        end else begin
            state        <= state_nx;
            O_wr_en      <= hit;
            O_frame_done <= frame_end;

            if (hit) begin
                O_wr_addr  <= addr_c;
                O_wr_data  <= rgb_q;
                col        <= col + 1'b1;
                next_x     <= next_x + X_STEP_P;
                sample_cnt <= sample_cnt + 1'b1;
            end

            if (de_fall) begin
                col    <= '0;
                next_x <= X_FIRST_P;
                if (x_cnt > line_max) begin
                    line_max <= x_cnt;
                end
            end

            if (row_adv) begin
                row    <= row + 1'b1;
                next_y <= next_y + Y_STEP_P;
            end

            if (frame_end) begin
                O_h_active       <= line_max;
                O_v_active       <= y_cnt;
                O_frame_complete <= (sample_cnt == SCNT_W'(N_SAMPLES));
            end

            // Column tracker is also reloaded here so a frame that starts right
            // after reset does not sample at x=0.
            if (vs_rise) begin
                col        <= '0;
                next_x     <= X_FIRST_P;
                row        <= '0;
                next_y     <= Y_FIRST_P;
                sample_cnt <= '0;
                line_max   <= '0;
            end
        end
    end

endmodule
